// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the 4-phase req/ack handshake transmitter.
//   hs_state_t  : transmitter FSM state encoding
//   *_MIN/*_MAX : legal parameter ranges, checked at elaboration in cdc_hs_tx
//   cnt_width() : counter width for a given SETUP_CYCLES/TIMEOUT pair
package cdc_hs_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      WAIT_ACK_HI,
      WAIT_ACK_LO
   } hs_state_t;

   localparam int unsigned SETUP_MIN = 1;
   localparam int unsigned SETUP_MAX = 15;
   localparam int unsigned SYNC_MIN  = 2;
   localparam int unsigned SYNC_MAX  = 4;
   localparam int unsigned CNT_W_MIN = 10;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Never narrower than 10 bits, wider only when the parameters need it.
   function automatic int unsigned cnt_width(input int unsigned setup, input int unsigned timeout);
      return max_u($clog2(max_u(setup, timeout) + 1), CNT_W_MIN);
   endfunction

   // Width for the default parameter set.
   localparam int unsigned CNT_W = cnt_width(2, 1023);

endpackage

// File: rtl/sync_bit_n.sv
// Multi-flop single-bit synchronizer for an asynchronous input.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, clears all stages to 0
//   d_i   : asynchronous input bit
//   q_o   : synchronized output (last stage)
module sync_bit_n #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-domain side of a 4-phase req/ack handshake carrying one data word
// into another clock domain. The word is held on data_out from acceptance
// until the next acceptance; req_out rises SETUP_CYCLES edges later and the
// transfer completes once the synchronized ack has risen and fallen again.
//   clk, reset         : clock, synchronous active-high reset
//   in_valid/in_ready  : source word handshake (ready only in IDLE)
//   in_data            : word to send
//   data_out, req_out  : registered outputs towards the far domain
//   ack_in             : far-domain acknowledge, asynchronous to clk
//   done               : one-cycle pulse per completed transfer
//   timeout_err        : one-cycle pulse when ack never rose within TIMEOUT
//   err_sticky         : latched timeout indication, cleared by reset only
module cdc_hs_tx
   import cdc_hs_pkg::*;
#(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned SETUP_CYCLES = 2,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned TIMEOUT      = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] data_out,
   output logic              req_out,
   input  logic              ack_in,
   output logic              done,
   output logic              timeout_err,
   output logic              err_sticky
);

   localparam int unsigned        TX_CNT_W   = cnt_width(SETUP_CYCLES, TIMEOUT);
   localparam logic [TX_CNT_W-1:0] SETUP_LAST = TX_CNT_W'(SETUP_CYCLES - 1);
   localparam logic [TX_CNT_W-1:0] TO_LAST    = (TIMEOUT == 0) ? '0 : TX_CNT_W'(TIMEOUT - 1);
   localparam logic [TX_CNT_W-1:0] CNT_ONE    = TX_CNT_W'(1);

   if ((SETUP_CYCLES < SETUP_MIN) || (SETUP_CYCLES > SETUP_MAX)) begin : g_bad_setup
      $error("cdc_hs_tx: SETUP_CYCLES out of range 1..15");
   end
   if ((SYNC_STAGES < SYNC_MIN) || (SYNC_STAGES > SYNC_MAX)) begin : g_bad_sync
      $error("cdc_hs_tx: SYNC_STAGES out of range 2..4");
   end

   logic ack_s;

   sync_bit_n #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (ack_in),
      .q_o   (ack_s)
   );

   hs_state_t           state_q;
   logic [TX_CNT_W-1:0] cnt_q;
   logic [DATA_W-1:0]   data_q;
   logic                req_q;
   logic                ready_q;
   logic                done_q;
   logic                terr_q;
   logic                sticky_q;
   logic                abort_q;   // current WAIT_ACK_LO follows a timeout

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         data_q   <= '0;
         req_q    <= 1'b0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         terr_q   <= 1'b0;
         sticky_q <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         terr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid && ready_q) begin
                  data_q  <= in_data;
                  cnt_q   <= '0;
                  ready_q <= 1'b0;
                  state_q <= SETUP;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            SETUP: begin
               if (cnt_q == SETUP_LAST) begin
                  req_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= WAIT_ACK_HI;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            WAIT_ACK_HI: begin
               if (cnt_q != '1) begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
               // ack is tested first so a coincident timeout is not reported
               if (ack_s) begin
                  req_q   <= 1'b0;
                  abort_q <= 1'b0;
                  state_q <= WAIT_ACK_LO;
               end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                  req_q    <= 1'b0;
                  terr_q   <= 1'b1;
                  sticky_q <= 1'b1;
                  abort_q  <= 1'b1;
                  state_q  <= WAIT_ACK_LO;
               end
            end
            WAIT_ACK_LO: begin
               if (!ack_s) begin
                  done_q  <= !abort_q;
                  abort_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = ready_q;
   assign data_out    = data_q;
   assign req_out     = req_q;
   assign done        = done_q;
   assign timeout_err = terr_q;
   assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
module tb_cdc_hs_tx;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] data_out;
   logic        req_out;
   logic        ack_in;
   logic        done;
   logic        timeout_err;
   logic        err_sticky;

   logic        man_ack;
   logic        resp_en;
   logic        resp_ack;
   logic        resp_req_q;
   logic        cap_en;
   logic [31:0] cap_q[$];

   int n_cmp  = 0;
   int n_fail = 0;
   int viol   = 0;

   int t_rise, t_fall, t_done, t_terr, t_ready, n_done, n_terr;
   logic rdy_at_done;

   cdc_hs_tx #(
      .DATA_W       (32),
      .SETUP_CYCLES (2),
      .SYNC_STAGES  (2),
      .TIMEOUT      (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .data_out    (data_out),
      .req_out     (req_out),
      .ack_in      (ack_in),
      .done        (done),
      .timeout_err (timeout_err),
      .err_sticky  (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ack_in = resp_en ? resp_ack : man_ack;

   // Far-end responder: ack follows req one cycle late, captures the word on req rise.
   always @(posedge clk) begin
      if (reset || !resp_en) resp_ack <= 1'b0;
      else                   resp_ack <= req_out;
      resp_req_q <= req_out;
      if (cap_en && req_out && !resp_req_q) cap_q.push_back(data_out);
   end

   // data_out may only change on an accept edge (or on reset).
   always @(posedge clk) begin
      logic [31:0] pd;
      logic        pr, pa, prst;
      pd   = data_out;
      pr   = req_out;
      pa   = in_valid && in_ready;
      prst = reset;
      #1;
      if (!prst && (data_out !== pd) && (!pa || pr)) viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [31:0] w);
      in_data  = w;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Runs n edges after the accept edge, logging event edge indices (1-based).
   task automatic observe(input int n, input int on_t, input int off_t);
      logic prev_req;
      t_rise = -1; t_fall = -1; t_done = -1; t_terr = -1; t_ready = -1;
      n_done = 0;  n_terr = 0;  rdy_at_done = 1'b0;
      prev_req = req_out;
      for (int k = 1; k <= n; k++) begin
         tick();
         if (req_out && !prev_req && t_rise < 0) t_rise = k;
         if (!req_out && prev_req && t_fall < 0) t_fall = k;
         prev_req = req_out;
         if (done) begin
            n_done++;
            if (t_done < 0) t_done = k;
            rdy_at_done = in_ready;
         end
         if (timeout_err) begin
            n_terr++;
            if (t_terr < 0) t_terr = k;
         end
         if (in_ready && t_ready < 0) t_ready = k;
         if (k == on_t)  man_ack = 1'b1;
         if (k == off_t) man_ack = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nacc, ndone;
      logic acc;
      reset = 1'b1; in_valid = 1'b0; in_data = '0;
      man_ack = 1'b0; resp_en = 1'b0; cap_en = 1'b0;
      tick(); tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_req", req_out, 0);
      check("rst_data", data_out, 0);
      check("rst_done", done, 0);
      check("rst_terr", timeout_err, 0);
      check("rst_sticky", err_sticky, 0);
      reset = 1'b0;
      tick();
      check("ready_after_rst", in_ready, 1);

      // basic transfer
      resp_en = 1'b1;
      start(32'hDEADBEEF);
      check("basic_data_e0", data_out, 32'hDEADBEEF);
      check("basic_busy", in_ready, 0);
      observe(14, -1, -1);
      check("basic_req_rise", t_rise, 2);
      check("basic_req_fall", t_fall, 6);
      check("basic_done_t", t_done, 10);
      check("basic_done_n", n_done, 1);
      check("basic_terr_n", n_terr, 0);
      check("basic_ready_at_done", rdy_at_done, 1);
      check("basic_data_hold", data_out, 32'hDEADBEEF);

      // back-to-back with in_valid held high
      cap_en = 1'b1; nacc = 0; ndone = 0;
      in_data = 32'h1; in_valid = 1'b1;
      for (int k = 0; k < 45; k++) begin
         acc = in_valid && in_ready;
         tick();
         if (done) ndone++;
         if (acc) begin
            nacc++;
            in_data = nacc + 1;
            if (nacc == 3) in_valid = 1'b0;
         end
      end
      cap_en = 1'b0;
      check("b2b_accepts", nacc, 3);
      check("b2b_done_n", ndone, 3);
      check("b2b_cap_n", cap_q.size(), 3);
      if (cap_q.size() == 3) begin
         check("b2b_cap0", cap_q[0], 32'h1);
         check("b2b_cap1", cap_q[1], 32'h2);
         check("b2b_cap2", cap_q[2], 32'h3);
      end
      resp_en = 1'b0;
      tick(); tick(); tick(); tick();

      // timeout with ack held low
      start(32'hA5);
      observe(25, -1, -1);
      check("to_req_rise", t_rise, 2);
      check("to_req_fall", t_fall, 18);
      check("to_terr_t", t_terr, 18);
      check("to_terr_n", n_terr, 1);
      check("to_done_n", n_done, 0);
      check("to_ready_t", t_ready, 19);
      check("to_sticky", err_sticky, 1);

      // ack_s reaches the FSM on the same edge as the timeout count
      start(32'h3C);
      observe(30, 15, 20);
      check("sim_req_fall", t_fall, 18);
      check("sim_terr_n", n_terr, 0);
      check("sim_done_t", t_done, 23);
      check("sim_done_n", n_done, 1);

      // reset during WAIT_ACK_HI
      start(32'h77);
      observe(4, -1, -1);
      check("mid_req_before", req_out, 1);
      reset = 1'b1;
      tick();
      check("mid_req", req_out, 0);
      check("mid_data", data_out, 0);
      check("mid_sticky", err_sticky, 0);
      check("mid_done", done, 0);
      reset = 1'b0;
      tick();
      check("mid_ready_after", in_ready, 1);
      check("mid_done_after", done, 0);

      // stale ack already high before accept
      man_ack = 1'b1;
      tick(); tick(); tick();
      start(32'h5A);
      observe(14, -1, 6);
      check("stale_req_rise", t_rise, 2);
      check("stale_req_fall", t_fall, 3);
      check("stale_done_t", t_done, 9);
      check("stale_done_n", n_done, 1);
      check("stale_terr_n", n_terr, 0);

      check("data_stable", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cdc_hs_tx.md
Name: cdc_hs_tx

Overview:
- Source-domain transmitter of a 4-phase req/ack handshake that moves a data word into another clock domain.
- Latches the word and holds it stable on data_out, then raises req_out after a setup delay.
- Waits for the far-end ack, which arrives asynchronously and is synchronized internally, then completes the return-to-zero phase.
- Sits on the sending side of audio-clock-mux control and status crossings; the far end double-flops req_out and samples data_out.

Parameters:
- DATA_W, 32, width of transferred word.
- SETUP_CYCLES, 2, cycles data_out is stable before req_out rises; legal range 1..15.
- SYNC_STAGES, 2, flops in the ack_in synchronizer; legal range 2..4.
- TIMEOUT, 1023, max cycles in WAIT_ACK_HI before abort; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  source has a word.
- in_ready  out  1  block can accept a word; high only in IDLE.
- in_data  in  DATA_W  word to send.
- data_out  out  DATA_W  word presented to far domain; registered.
- req_out  out  1  handshake request; registered, glitch-free.
- ack_in  in  1  far-domain acknowledge; asynchronous to clk.
- done  out  1  one-cycle pulse: transfer completed.
- timeout_err  out  1  one-cycle pulse: ack never rose within TIMEOUT.
- err_sticky  out  1  set by timeout_err; cleared only by reset.

Behaviour:
- Reset values: in_ready=0 while reset is high, 1 on the first cycle after reset; req_out=0; data_out=0; done=0; timeout_err=0; err_sticky=0; synchronizer flops=0; state=IDLE; counters=0.
- ack_in passes through SYNC_STAGES flops marked ASYNC_REG to produce ack_s. The FSM uses only ack_s, never ack_in.
- FSM states: IDLE, SETUP, WAIT_ACK_HI, WAIT_ACK_LO.
- IDLE: in_ready=1. On in_valid&in_ready at edge E0: data_out<=in_data, cnt<=0, go to SETUP. data_out changes only on this accept edge.
- SETUP: cnt increments each cycle. When cnt==SETUP_CYCLES-1: req_out<=1, cnt<=0, go to WAIT_ACK_HI. req_out therefore rises at edge E0+SETUP_CYCLES.
- WAIT_ACK_HI, ack_s==1: req_out<=0, go to WAIT_ACK_LO.
- WAIT_ACK_HI, TIMEOUT!=0 and cnt==TIMEOUT-1 and ack_s==0: req_out<=0, pulse timeout_err, set err_sticky, go to WAIT_ACK_LO. The transfer is aborted and done is not pulsed for it.
- WAIT_ACK_HI, both conditions on the same cycle: ack_s wins; no error is raised.
- WAIT_ACK_LO: wait for ack_s==0, then pulse done (unless this is an abort), go to IDLE. in_ready is high the following cycle. There is no timeout in this state.
- Latency with ack_in driven by an ideal responder that acks immediately, measured from accept edge E0:
  - req rises at E0+SETUP_CYCLES.
  - req falls SYNC_STAGES+1 edges after ack_in rises.
  - done pulses SYNC_STAGES+1 edges after ack_in falls.
- Back-to-back transfers: a new word can be accepted no earlier than the cycle after done.
- ack_s already high in IDLE (stale or protocol error): the word is still accepted. SETUP proceeds normally; WAIT_ACK_HI exits immediately on ack_s==1. No error is flagged.
- in_valid during a busy state is ignored; in_ready=0 there, so no data is lost.
- Reset mid-transfer: on the next edge req_out=0, data_out=0, state=IDLE, no done pulse. The far end must tolerate req dropping early.
- Counter: 10 bits, or wider as needed for max(SETUP_CYCLES, TIMEOUT). It saturates and never wraps.

Decomposition:
- Package cdc_hs_pkg holds:
  - typedef enum logic[1:0] hs_state_t {IDLE, SETUP, WAIT_ACK_HI, WAIT_ACK_LO};
  - localparam CNT_W = $clog2(max(SETUP_CYCLES, TIMEOUT)+1);
  - the legal-range check constants for the parameters.
- One sub-module, sync_bit_n: SYNC_STAGES-deep single-bit synchronizer with ASYNC_REG attributes and synchronous reset to 0. Instantiated once for ack_in.

Test Plan:
- Basic transfer. DATA_W=32, SETUP_CYCLES=2, SYNC_STAGES=2; in_data=0xDEADBEEF accepted at E0; responder acks 1 cycle after req and drops ack 1 cycle after req falls.
  - Required: data_out=0xDEADBEEF from E0 and stable throughout.
  - Required: req_out high at E0+2; done is a single pulse; in_ready=1 the next cycle.
- Back-to-back. Three words 0x1, 0x2, 0x3 with in_valid held high.
  - Required: exactly three done pulses.
  - Required: data_out never changes while req_out=1 or ack_s=1.
  - Required: the responder captures 1, 2, 3 in order.
- Timeout. TIMEOUT=16; ack_in held 0.
  - Required: req_out falls 16 cycles after rising; timeout_err pulses once; err_sticky=1; done not pulsed.
  - Required: back in IDLE once ack_s=0.
- Simultaneous ack and timeout. ack_in timed so ack_s rises on cycle cnt==TIMEOUT-1.
  - Required: no timeout_err; normal done pulse.
- Reset mid-transfer. Assert reset for 1 cycle while in WAIT_ACK_HI.
  - Required: next edge req_out=0, data_out=0, err_sticky=0, no done pulse.
  - Required: in_ready=1 the cycle after reset deasserts.
- Stale ack. ack_in=1 before accept.
  - Required: req_out rises at E0+2 and falls 1 cycle later.
  - Required: block waits in WAIT_ACK_LO until ack_in falls, then pulses done.
